// File: rtl/alu_mc_unit.sv
// alu_mc_unit: registered ALU-op decode and execute with an iterative shift-add multiplier
module alu_mc_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       aluop_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] op_res, mcand, mplier, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             accept, mul_last;
  assign accept   = state == IDLE && valid_i && !flush_i;
  assign mul_last = cnt == CW'(1);
  assign busy_o   = state == MUL;
  // decode op class / funct into a control code and compute single-cycle results
  always_comb begin
    ctrl = aluop_i == 2'b00 ? OP_ADD :
           aluop_i == 2'b01 ? OP_SUB :
           aluop_i == 2'b11 ? OP_OR  :
           funct_i == 6'b100000 ? OP_ADD :
           funct_i == 6'b100010 ? OP_SUB :
           funct_i == 6'b100100 ? OP_AND :
           funct_i == 6'b100101 ? OP_OR  :
           funct_i == 6'b011000 ? OP_MUL : OP_NONE;
    op_res = ctrl == OP_ADD ? data1_i + data2_i :
             ctrl == OP_SUB ? data1_i - data2_i :
             ctrl == OP_AND ? data1_i & data2_i :
             ctrl == OP_OR  ? data1_i | data2_i : '0;
    acc_step = acc + (mplier[0] ? mcand : '0);
  end
  // next state: enter MUL on an accepted mul, leave on last step or flush
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (accept && ctrl == OP_MUL ? MUL : IDLE) :
                (flush_i || mul_last ? IDLE : MUL);
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  // datapath: operand capture, shift-add step and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o <= '0;
      zero_o   <= 1'b1;
      valid_o  <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE) begin
        if (accept && ctrl == OP_MUL) begin
          mcand  <= data1_i;
          mplier <= data2_i;
          acc    <= '0;
          cnt    <= CW'(WIDTH);
        end else if (accept) begin
          result_o <= op_res;
          zero_o   <= op_res == '0;
          valid_o  <= 1'b1;
        end
      end else if (flush_i) begin
        cnt <= '0;
      end else begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (mul_last) begin
          result_o <= acc_step;
          zero_o   <= acc_step == '0;
          valid_o  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc_unit.sv
// tb_alu_mc_unit: randomized and directed checks of alu_mc_unit against a behavioural model
module tb_alu_mc_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, valid, flush, zero, vo, busy;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [31:0] d1, d2, result;
  logic valid8, flush8, zero8, vo8, busy8;
  logic [1:0] aluop8;
  logic [5:0] funct8;
  logic [7:0] a8, b8, res8;
  int checks = 0, errors = 0;

  alu_mc_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .aluop_i(aluop),
    .funct_i(funct), .data1_i(d1), .data2_i(d2), .result_o(result), .zero_o(zero),
    .valid_o(vo), .busy_o(busy));

  alu_mc_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid8), .flush_i(flush8), .aluop_i(aluop8),
    .funct_i(funct8), .data1_i(a8), .data2_i(b8), .result_o(res8), .zero_o(zero8),
    .valid_o(vo8), .busy_o(busy8));

  function automatic logic [32:0] model(input logic [1:0] op, input logic [5:0] f,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0: return {1'b0, a + b};
      2'd1: return {1'b0, a - b};
      2'd3: return {1'b0, a | b};
      default: case (f)
        6'h20: return {1'b0, a + b};
        6'h22: return {1'b0, a - b};
        6'h24: return {1'b0, a & b};
        6'h25: return {1'b0, a | b};
        6'h18: return {1'b1, p[31:0]};
        default: return 33'd0;
      endcase
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = 1; aluop = op; funct = f; d1 = a; d2 = b;
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    checks++;
    if (result !== 0 || zero !== 1 || vo !== 0 || busy !== 0) begin
      errors++; $display("FAIL reset_init got res=%h z=%b v=%b b=%b want 0 1 0 0", result, zero, vo, busy);
    end
    rst = 0;
    tick; tick; tick;
    checks++;
    if (result !== 0 || zero !== 1 || vo !== 0 || busy !== 0) begin
      errors++; $display("FAIL reset_idle got res=%h z=%b v=%b b=%b want 0 1 0 0", result, zero, vo, busy);
    end
  endtask

  task automatic test_async_reset;
    set_op(0, 0, 32'h1234, 1); tick;
    set_op(2, 6'h18, 9, 9); tick; valid = 0;
    tick;
    checks++;
    if (result !== 32'h1235 || busy !== 1) begin
      errors++; $display("FAIL areset_pre got res=%h b=%b want 00001235 1", result, busy);
    end
    #3 rst = 1;
    #1;
    checks++;
    if (result !== 0 || zero !== 1 || vo !== 0 || busy !== 0 || res8 !== 0 || zero8 !== 1) begin
      errors++; $display("FAIL areset got res=%h z=%b v=%b b=%b want 0 1 0 0", result, zero, vo, busy);
    end
    tick; rst = 0;
    tick; tick; tick;
    checks++;
    if (result !== 0 || zero !== 1 || vo !== 0 || busy !== 0) begin
      errors++; $display("FAIL areset_idle got res=%h z=%b v=%b b=%b want 0 1 0 0", result, zero, vo, busy);
    end
  endtask

  task automatic test_decode;
    logic [1:0]  ops [8] = '{2, 2, 2, 2, 2, 0, 1, 3};
    logic [5:0]  fs  [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 0, 0, 0};
    logic [31:0] as  [8] = '{32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 7, 7, 7};
    logic [31:0] bs  [8] = '{32'h0F, 32'h0F, 32'h0F, 32'h0F, 32'h0F, 5, 5, 5};
    logic [31:0] ex  [8] = '{32'hFF, 32'hE1, 32'h0, 32'hFF, 32'h0, 12, 2, 7};
    for (int i = 0; i < 8; i++) begin
      set_op(ops[i], fs[i], as[i], bs[i]); tick; valid = 0;
      checks++;
      if (vo !== 1 || result !== ex[i] || zero !== (ex[i] == 0)) begin
        errors++; $display("FAIL decode%0d got v=%b res=%h z=%b want 1 %h %b", i, vo, result, zero, ex[i], ex[i] == 0);
      end
      tick;
      checks++;
      if (vo !== 0) begin
        errors++; $display("FAIL decode%0d_pulse got v=%b want 0", i, vo);
      end
    end
  endtask

  task automatic test_wrap;
    set_op(2, 6'h20, 32'hFFFF_FFFF, 1); tick;
    checks++;
    if (vo !== 1 || result !== 0 || zero !== 1) begin
      errors++; $display("FAIL wrap_add got v=%b res=%h z=%b want 1 0 1", vo, result, zero);
    end
    set_op(2, 6'h22, 0, 1); tick; valid = 0;
    checks++;
    if (vo !== 1 || result !== 32'hFFFF_FFFF || zero !== 0) begin
      errors++; $display("FAIL wrap_sub got v=%b res=%h z=%b want 1 ffffffff 0", vo, result, zero);
    end
    tick;
  endtask

  task automatic test_mul;
    logic [31:0] as [3] = '{6, 32'hFFFF_FFFD, 32'h0001_0000};
    logic [31:0] bs [3] = '{7, 5, 32'h0001_0000};
    logic [31:0] ex [3] = '{42, 32'hFFFF_FFF1, 0};
    int bc, early;
    set_op(2, 6'h18, as[0], bs[0]); tick;
    for (int i = 0; i < 3; i++) begin
      valid = 0; d1 = $urandom; d2 = $urandom;
      bc = 0; early = 0;
      while (busy && bc < 40) begin
        if (vo) early++;
        bc++; tick;
      end
      checks++;
      if (bc !== 32 || early !== 0) begin
        errors++; $display("FAIL mul%0d_busy got cycles=%0d early=%0d want 32 0", i, bc, early);
      end
      checks++;
      if (vo !== 1 || result !== ex[i] || zero !== (ex[i] == 0)) begin
        errors++; $display("FAIL mul%0d got v=%b res=%h z=%b want 1 %h %b", i, vo, result, zero, ex[i], ex[i] == 0);
      end
      if (i < 2) set_op(2, 6'h18, as[i+1], bs[i+1]);
      tick;
      checks++;
      if (vo !== 0 || busy !== (i < 2)) begin
        errors++; $display("FAIL mul%0d_next got v=%b b=%b want 0 %b", i, vo, busy, i < 2);
      end
    end
  endtask

  task automatic test_stall;
    int bc, early;
    set_op(2, 6'h18, 6, 7); tick;
    set_op(2, 6'h20, 1, 1);
    bc = 0; early = 0;
    while (busy && bc < 40) begin
      if (vo) early++;
      bc++; tick;
    end
    checks++;
    if (bc !== 32 || early !== 0 || vo !== 1 || result !== 42) begin
      errors++; $display("FAIL stall_mul got cycles=%0d early=%0d v=%b res=%h want 32 0 1 0000002a", bc, early, vo, result);
    end
    tick; valid = 0;
    checks++;
    if (vo !== 1 || result !== 2 || busy !== 0) begin
      errors++; $display("FAIL stall_add got v=%b res=%h b=%b want 1 00000002 0", vo, result, busy);
    end
    tick;
    checks++;
    if (vo !== 0) begin
      errors++; $display("FAIL stall_pulse got v=%b want 0", vo);
    end
  endtask

  task automatic test_flush;
    set_op(3, 0, 32'h50, 32'h05); tick;
    set_op(2, 6'h18, 3, 3); tick; valid = 0;
    for (int k = 0; k < 9; k++) tick;
    flush = 1; tick; flush = 0;
    checks++;
    if (busy !== 0 || vo !== 0 || result !== 32'h55) begin
      errors++; $display("FAIL flush_mul got b=%b v=%b res=%h want 0 0 00000055", busy, vo, result);
    end
    tick;
    checks++;
    if (vo !== 0 || result !== 32'h55) begin
      errors++; $display("FAIL flush_after got v=%b res=%h want 0 00000055", vo, result);
    end
    set_op(0, 0, 1, 1); flush = 1; tick; valid = 0; flush = 0;
    checks++;
    if (vo !== 0 || busy !== 0 || result !== 32'h55) begin
      errors++; $display("FAIL flush_idle got v=%b b=%b res=%h want 0 0 00000055", vo, busy, result);
    end
    tick;
  endtask

  task automatic test_random;
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h00};
    logic [32:0] m;
    logic [5:0] f;
    int bc;
    for (int i = 0; i < 40; i++) begin
      f = fl[$urandom_range(0, 5)];
      if (f == 0) f = 6'($urandom);
      set_op(2'($urandom_range(0, 3)), f, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      m = model(aluop, funct, d1, d2);
      tick; valid = 0;
      bc = 0;
      if (m[32]) begin
        d1 = $urandom; d2 = $urandom;
        while (busy && bc < 40) begin bc++; tick; end
      end
      checks++;
      if (vo !== 1 || result !== m[31:0] || zero !== (m[31:0] == 0) || bc !== (m[32] ? 32 : 0)) begin
        errors++; $display("FAIL rand%0d got v=%b res=%h z=%b cyc=%0d want 1 %h %b %0d", i, vo, result, zero, bc, m[31:0], m[31:0] == 0, m[32] ? 32 : 0);
      end
    end
    tick;
  endtask

  task automatic test_width8;
    int bc;
    valid8 = 1; aluop8 = 2; funct8 = 6'h18; a8 = 15; b8 = 17; tick;
    valid8 = 0; a8 = 8'hAA; b8 = 8'h55;
    bc = 0;
    while (busy8 && bc < 20) begin bc++; tick; end
    checks++;
    if (bc !== 8 || vo8 !== 1 || res8 !== 8'hFF || zero8 !== 0) begin
      errors++; $display("FAIL w8_mul got cyc=%0d v=%b res=%h z=%b want 8 1 ff 0", bc, vo8, res8, zero8);
    end
    valid8 = 1; aluop8 = 0; a8 = 8'h80; b8 = 8'h80; tick; valid8 = 0;
    checks++;
    if (vo8 !== 1 || res8 !== 0 || zero8 !== 1) begin
      errors++; $display("FAIL w8_add got v=%b res=%h z=%b want 1 00 1", vo8, res8, zero8);
    end
    tick;
  endtask

  initial begin
    rst = 1; valid = 0; flush = 0; aluop = 0; funct = 0; d1 = 0; d2 = 0;
    valid8 = 0; flush8 = 0; aluop8 = 0; funct8 = 0; a8 = 0; b8 = 0;
    test_reset;
    test_decode;
    test_wrap;
    test_mul;
    test_stall;
    test_flush;
    test_random;
    test_width8;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
